// File: rtl/crypto1_mul_arb_pkg.sv
// rtl/crypto1_mul_arb_pkg.sv - shared defaults, id width helper and result type for the multiplier arbiter
package crypto1_mul_arb_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DW      = 12;
    localparam int DEF_DOUT_W  = 12;
    localparam int DEF_CNT_W   = 16;

    function automatic int id_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    typedef struct packed {
        logic [DEF_DOUT_W-1:0]          data;
        logic [id_w(DEF_NUM_REQ)-1:0]   id;
    } mul_rsp_t;

endpackage

// File: rtl/crypto1_rr_arbiter.sv
// rtl/crypto1_rr_arbiter.sv - rotating-priority one-hot grant with its round-robin pointer
module crypto1_rr_arbiter
    import crypto1_mul_arb_pkg::*;
#(
    parameter int N   = DEF_NUM_REQ,
    parameter int IDW = id_w(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           en,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_idx
);

    logic [IDW-1:0] rr_ptr_q;
    logic [IDW-1:0] rr_ptr_d;
    logic           found;

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N) s = s - N;
        return IDW'(s);
    endfunction

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[wrap_add(rr_ptr_q, k)]) begin
                grant[wrap_add(rr_ptr_q, k)] = 1'b1;
                grant_idx                    = wrap_add(rr_ptr_q, k);
                found                        = 1'b1;
            end
        end
    end

    // Pointer moves only when the grant is actually taken.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (en && found) rr_ptr_d = wrap_add(grant_idx, 1);
    end

    always_ff @(posedge clk) begin
        if (rst) rr_ptr_q <= '0;
        else     rr_ptr_q <= rr_ptr_d;
    end

endmodule

// File: rtl/crypto1_mul_arbiter.sv
// rtl/crypto1_mul_arbiter.sv - one signed multiplier shared round-robin between requesters
module crypto1_mul_arbiter
    import crypto1_mul_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DW      = DEF_DW,
    parameter int DOUT_W  = DEF_DOUT_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int IDW     = id_w(NUM_REQ)
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*DW-1:0] req_a,
    input  logic [NUM_REQ*DW-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DOUT_W-1:0]     rsp_data,
    output logic [IDW-1:0]        rsp_id,
    output logic [CNT_W-1:0]      op_count
);

    typedef struct packed {
        logic [DOUT_W-1:0] data;
        logic [IDW-1:0]    id;
    } rsp_t;

    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     grant_idx;
    logic               can_acc;
    logic               acc;
    logic [DW-1:0]      a_sel;
    logic [DW-1:0]      b_sel;
    logic [2*DW-1:0]    a_ext;
    logic [2*DW-1:0]    b_ext;
    rsp_t               rsp_q;
    rsp_t               rsp_d;
    logic               rsp_valid_q;
    logic               rsp_valid_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    assign can_acc   = !rsp_valid_q || rsp_ready;
    assign req_ready = ap_rst ? '0 : (grant & {NUM_REQ{can_acc}});
    assign acc       = |req_ready;

    crypto1_rr_arbiter #(.N(NUM_REQ), .IDW(IDW)) u_arb (
        .clk       (ap_clk),
        .rst       (ap_rst),
        .req       (req_valid),
        .en        (acc),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign a_sel = req_a[int'(grant_idx)*DW +: DW];
    assign b_sel = req_b[int'(grant_idx)*DW +: DW];
    assign a_ext = {{DW{a_sel[DW-1]}}, a_sel};
    assign b_ext = {{DW{b_sel[DW-1]}}, b_sel};

    // A new accept overwrites the held result even while it is draining.
    always_comb begin
        rsp_d       = rsp_q;
        rsp_valid_d = rsp_valid_q;
        cnt_d       = cnt_q;
        if (acc) begin
            rsp_d.data  = DOUT_W'(a_ext * b_ext);
            rsp_d.id    = grant_idx;
            rsp_valid_d = 1'b1;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
        if (rsp_valid_q && rsp_ready && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            rsp_q       <= rsp_d;
            rsp_valid_q <= rsp_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_q.data;
    assign rsp_id    = rsp_q.id;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_crypto1_mul_arbiter.sv
// tb/tb_crypto1_mul_arbiter.sv - directed checks of the shared multiplier arbiter
module tb_crypto1_mul_arbiter;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [47:0] req_a;
    logic [47:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [11:0] rsp_data;
    logic [1:0]  rsp_id;
    logic [15:0] op_count;

    int checks = 0;
    int errors = 0;

    crypto1_mul_arbiter dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .op_count  (op_count)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge ap_clk);
        #1;
    endtask

    task automatic check_rsp(input string tag, input logic v, input logic [11:0] d,
                             input logic [1:0] id, input logic [15:0] cnt);
        check_eq({tag, "_valid"}, 32'(rsp_valid), 32'(v));
        check_eq({tag, "_data"},  32'(rsp_data),  32'(d));
        check_eq({tag, "_id"},    32'(rsp_id),    32'(id));
        check_eq({tag, "_cnt"},   32'(op_count),  32'(cnt));
    endtask

    logic [1:0]  exp_id  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [11:0] exp_dat [6] = '{12'h003, 12'h006, 12'h009, 12'h00C, 12'h003, 12'h006};

    initial begin
        ap_rst    = 1'b1;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        step;
        step;
        check_eq("rst_ready", 32'(req_ready), 32'h0);
        check_rsp("rst", 1'b0, 12'h000, 2'd0, 16'd0);

        // single requester, positive overflow of the 12-bit result
        ap_rst    = 1'b0;
        req_valid = 4'b0001;
        req_a[0 +: 12] = 12'h7FF;
        req_b[0 +: 12] = 12'h002;
        rsp_ready = 1'b1;
        #1 check_eq("t1_ready", 32'(req_ready), 32'h1);
        step;
        check_rsp("t1", 1'b1, 12'hFFE, 2'd0, 16'd0);

        req_valid = 4'b0100;
        req_a[24 +: 12] = 12'hFFD;
        req_b[24 +: 12] = 12'h005;
        #1 check_eq("t2a_ready", 32'(req_ready), 32'h4);
        step;
        check_rsp("t2a", 1'b1, 12'hFF1, 2'd2, 16'd1);
        req_a[24 +: 12] = 12'h800;
        req_b[24 +: 12] = 12'h800;
        step;
        check_rsp("t2b", 1'b1, 12'h000, 2'd2, 16'd2);

        // backpressure: result frozen, nothing accepted
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        req_a[12 +: 12] = 12'h010;
        req_b[12 +: 12] = 12'hFFF;
        for (int k = 0; k < 3; k++) begin
            #1 check_eq("t4_ready_held", 32'(req_ready), 32'h0);
            step;
            check_rsp("t4_hold", 1'b1, 12'h000, 2'd2, 16'd2);
        end
        rsp_ready = 1'b1;
        #1 check_eq("t4_ready_drain", 32'(req_ready), 32'h2);
        step;
        check_rsp("t4_drain", 1'b1, 12'hFF0, 2'd1, 16'd3);

        // reset with a result in flight and rr_ptr at 2
        req_valid = 4'b0000;
        ap_rst    = 1'b1;
        step;
        check_rsp("t5", 1'b0, 12'h000, 2'd0, 16'd0);
        ap_rst = 1'b0;

        // all requesters valid: strict rotation from req0
        for (int i = 0; i < 4; i++) begin
            req_a[i*12 +: 12] = 12'(i + 1);
            req_b[i*12 +: 12] = 12'h003;
        end
        req_valid = 4'hF;
        #1 check_eq("t3_first_grant", 32'(req_ready), 32'h1);
        for (int k = 0; k < 6; k++) begin
            step;
            check_rsp($sformatf("t3_%0d", k), 1'b1, exp_dat[k], exp_id[k], 16'(k));
        end

        // run the counter up to saturation
        for (int k = 0; k < 16'hFFFE - 5; k++) @(posedge ap_clk);
        #1 check_eq("t6_fffe", 32'(op_count), 32'hFFFE);
        step;
        check_eq("t6_ffff", 32'(op_count), 32'hFFFF);
        step;
        step;
        check_eq("t6_sat", 32'(op_count), 32'hFFFF);
        step;
        check_eq("t6_sat2", 32'(op_count), 32'hFFFF);
        check_eq("t6_valid", 32'(rsp_valid), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
